memory_control: RTL and testbench

Arbitrates the instruction cache and data cache onto the single-ported RAM. It sits directly downstream of both caches on the `caches_if` side and upstream of the RAM model. Grants are registered and held until the RAM completes or the requester withdraws. The data cache has priority, with a bounded-starvation override for the instruction cache. Load data is registered so each cache samples it in the cycle after its wait drops.

---
 rtl/memory_control_if.sv | 33 +++
 rtl/memory_control.sv | 120 ++++++++++++
 tb/tb_memory_control.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_control_if.sv
// Cache-side and RAM-side signal bundle for the memory controller.
// master: the controller itself. slave: the environment (caches + RAM model).
interface memory_control_if;
  // icache side
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // dcache side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_control.sv
// Arbitrates icache and dcache onto a single-ported RAM. The dcache has
// priority; after IMAX_WAIT consecutive losses the icache wins once.
// Grants are registered; RAM strobes are combinational from the grant.
module memory_control #(
  parameter int unsigned IMAX_WAIT = 8
) (
  input logic              CLK,
  input logic              nRST,
  memory_control_if.master bus
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] iload_q, dload_q;

  logic        dreq;
  logic        starve;
  logic        ram_access;
  logic        ram_error;
  logic        i_rd_done;
  logic        d_rd_done;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store;

  assign dreq       = bus.dREN | bus.dWEN;
  assign starve     = (starve_cnt_q >= 4'(IMAX_WAIT));
  assign ram_access = (bus.ramstate == RAM_ACCESS);
  assign ram_error  = (bus.ramstate == RAM_ERROR);

  // A read completes only if the grantee is still reading when ACCESS arrives;
  // a write (even with dREN also high) never touches dload.
  assign d_rd_done = (state_q == DGRANT) && bus.dREN && !bus.dWEN && ram_access;
  assign i_rd_done = (state_q == IGRANT) && bus.iREN && ram_access;

  assign bus.iwait    = !((state_q == IGRANT) && ram_access);
  assign bus.dwait    = !((state_q == DGRANT) && ram_access);
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;

  // Next-state, starvation counter and RAM drive from the current grant.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ram_ren      = 1'b0;
    ram_wen      = 1'b0;
    ram_addr     = 32'd0;
    ram_store    = 32'd0;
    case (state_q)
      IDLE: begin
        if (dreq && !starve) begin
          state_d = DGRANT;
          // icache lost this round; saturate rather than wrap
          if (bus.iREN && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (bus.iREN) begin
          state_d      = IGRANT;
          starve_cnt_d = 4'd0;
        end
      end
      DGRANT: begin
        if (!dreq) begin
          state_d = IDLE;          // withdrawn: strobes stay low
        end else begin
          ram_addr = bus.daddr;
          if (bus.dWEN) begin
            ram_wen   = 1'b1;
            ram_store = bus.dstore;
          end else begin
            ram_ren = 1'b1;
          end
          // ERROR drops the grant so the request re-arbitrates as a retry
          if (ram_access || ram_error) state_d = IDLE;
        end
      end
      IGRANT: begin
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          ram_ren  = 1'b1;
          ram_addr = bus.iaddr;
          if (ram_access || ram_error) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant state and starvation counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Load registers capture ramload on read completion and hold otherwise.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iload_q <= 32'd0;
      dload_q <= 32'd0;
    end else begin
      if (i_rd_done) iload_q <= bus.ramload;
      if (d_rd_done) dload_q <= bus.ramload;
    end
  end

endmodule

// File: tb/tb_memory_control.sv
// Bench for memory_control: behavioural RAM with programmable latency and
// one-shot ERROR injection, plus a load-value scoreboard per cache.
module tb_memory_control;

  logic CLK = 1'b0;
  logic nRST;

  memory_control_if bus();

  memory_control #(.IMAX_WAIT(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.master)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // RAM model
  logic [31:0] mem [0:255];
  int unsigned lat;
  int unsigned err_req;
  int unsigned err_done;
  int unsigned acc_cnt;
  logic        strobe;

  assign strobe = bus.ramREN | bus.ramWEN;

  always_comb begin
    bus.ramload = mem[bus.ramaddr[7:0]];
    if (!strobe)                  bus.ramstate = 2'd0;
    else if (err_req != err_done) bus.ramstate = 2'd3;
    else if (acc_cnt + 1 >= lat)  bus.ramstate = 2'd2;
    else                          bus.ramstate = 2'd1;
  end

  always @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < 256; i++) mem[i] <= {24'hC0FFEE, 8'(i)};
      mem[8'h40] <= 32'hDEADBEEF;
      acc_cnt    <= 0;
      err_done   <= 0;
    end else if (strobe) begin
      acc_cnt <= acc_cnt + 1;
      if (err_req != err_done) err_done <= err_done + 1;
      if (bus.ramWEN && bus.ramstate == 2'd2) mem[bus.ramaddr[7:0]] <= bus.ramstore;
    end else begin
      acc_cnt <= 0;
    end
  end

  // Scoreboard: expected load values, popped when the cache's wait drops and
  // compared against the load register one cycle later.
  logic [31:0] iq [$];
  logic [31:0] dq [$];
  logic        ip = 1'b0, dp = 1'b0;
  logic [31:0] ip_exp, dp_exp;

  always @(negedge CLK) begin
    if (ip) begin chk("sb_iload", bus.iload, ip_exp); ip = 1'b0; end
    if (dp) begin chk("sb_dload", bus.dload, dp_exp); dp = 1'b0; end
    if (nRST && !bus.iwait) begin
      if (iq.size() == 0) chk("sb_i_unexpected", 32'd1, 32'd0);
      else begin ip_exp = iq.pop_front(); ip = 1'b1; end
    end
    if (nRST && !bus.dwait) begin
      if (dq.size() == 0) chk("sb_d_unexpected", 32'd1, 32'd0);
      else begin dp_exp = dq.pop_front(); dp = 1'b1; end
    end
  end

  logic [31:0] last_dload;
  logic [31:0] ctn_exp [12];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input bit is_i, input string tag);
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (is_i ? !bus.iwait : !bus.dwait) return;
    end
    chk(tag, 32'd0, 32'd1);
  endtask

  task automatic dread(input logic [31:0] addr, input int unsigned l);
    lat = l;
    bus.dREN = 1'b1;
    bus.daddr = addr;
    last_dload = mem[addr[7:0]];
    dq.push_back(last_dload);
    wait_done(1'b0, "dread_timeout");
    tick();
    bus.dREN = 1'b0;
  endtask

  task automatic iread(input logic [31:0] addr, input int unsigned l);
    lat = l;
    bus.iREN = 1'b1;
    bus.iaddr = addr;
    iq.push_back(mem[addr[7:0]]);
    wait_done(1'b1, "iread_timeout");
    tick();
    bus.iREN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    lat = 1; err_req = 0; last_dload = '0;
    ctn_exp = '{32'h0, 32'h84, 32'h0, 32'h84, 32'h0, 32'h48,
                32'h0, 32'h84, 32'h0, 32'h84, 32'h0, 32'h48};

    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ramREN",   32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr",  bus.ramaddr,     32'd0);
    chk("rst_ramstore", bus.ramstore,    32'd0);
    chk("rst_iwait",    32'(bus.iwait),  32'd1);
    chk("rst_dwait",    32'(bus.dwait),  32'd1);
    chk("rst_iload",    bus.iload,       32'd0);
    chk("rst_dload",    bus.dload,       32'd0);
    nRST = 1'b1;
    tick();

    // icache read, L=2, cycle by cycle
    lat = 2;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    iq.push_back(32'hDEADBEEF);
    @(negedge CLK);
    chk("ird_c0_ramREN", 32'(bus.ramREN), 32'd0);
    tick(); @(negedge CLK);
    chk("ird_c1_ramREN",  32'(bus.ramREN), 32'd1);
    chk("ird_c1_ramaddr", bus.ramaddr,     32'h40);
    chk("ird_c1_iwait",   32'(bus.iwait),  32'd1);
    tick(); @(negedge CLK);
    chk("ird_c2_ramREN", 32'(bus.ramREN), 32'd1);
    chk("ird_c2_iwait",  32'(bus.iwait),  32'd0);
    tick();
    bus.iREN = 1'b0;
    @(negedge CLK);
    chk("ird_c3_iload",  bus.iload,       32'hDEADBEEF);
    chk("ird_c3_ramREN", 32'(bus.ramREN), 32'd0);

    // dcache write with dREN also high, L=2
    lat = 2;
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h12345678;
    dq.push_back(last_dload);
    tick(); @(negedge CLK);
    chk("dwr_ramWEN",   32'(bus.ramWEN), 32'd1);
    chk("dwr_ramREN",   32'(bus.ramREN), 32'd0);
    chk("dwr_ramstore", bus.ramstore,    32'h12345678);
    chk("dwr_ramaddr",  bus.ramaddr,     32'h100);
    wait_done(1'b0, "dwr_timeout");
    tick();
    bus.dWEN = 1'b0; bus.dREN = 1'b0; bus.dstore = '0;

    // Read back the written word, then a plain icache read
    dread(32'h100, 3);
    chk("dread_back", last_dload, 32'h12345678);
    iread(32'h44, 1);

    // Contention with IMAX_WAIT=2, L=1: D, D, I, D, D, I
    lat = 1;
    bus.iREN = 1'b1; bus.iaddr = 32'h48;
    bus.dREN = 1'b1; bus.daddr = 32'h84;
    last_dload = mem[8'h84];
    for (int n = 0; n < 4; n++) dq.push_back(mem[8'h84]);
    for (int n = 0; n < 2; n++) iq.push_back(mem[8'h48]);
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      chk($sformatf("ctn_c%0d_ramaddr", c), bus.ramaddr, ctn_exp[c]);
      chk($sformatf("ctn_c%0d_ramREN", c), 32'(bus.ramREN), 32'(ctn_exp[c] != 32'h0));
      if (c < 11) tick();
    end
    tick();
    bus.iREN = 1'b0; bus.dREN = 1'b0;

    // Withdrawal in cycle 2 of DGRANT
    lat = 4;
    bus.dREN = 1'b1; bus.daddr = 32'h80;
    tick(); @(negedge CLK);
    chk("wd_c1_ramREN", 32'(bus.ramREN), 32'd1);
    tick();
    bus.dREN = 1'b0;
    @(negedge CLK);
    chk("wd_c2_ramREN", 32'(bus.ramREN), 32'd0);
    chk("wd_c2_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("wd_c2_dwait",  32'(bus.dwait),  32'd1);
    tick();
    lat = 1;
    bus.dREN = 1'b1;
    dq.push_back(mem[8'h80]);
    @(negedge CLK);
    chk("wd_c3_idle_ramREN", 32'(bus.ramREN), 32'd0);
    chk("wd_c3_dload_held",  bus.dload,       last_dload);
    last_dload = mem[8'h80];
    wait_done(1'b0, "wd_retry_timeout");
    tick();
    bus.dREN = 1'b0;

    // ERROR during IGRANT, then retry succeeds
    lat = 1;
    err_req = err_req + 1;
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    iq.push_back(mem[8'h44]);
    tick(); @(negedge CLK);
    chk("err_c1_ramREN", 32'(bus.ramREN), 32'd1);
    chk("err_c1_iwait",  32'(bus.iwait),  32'd1);
    tick(); @(negedge CLK);
    chk("err_c2_idle",   32'(bus.ramREN), 32'd0);
    chk("err_c2_iwait",  32'(bus.iwait),  32'd1);
    tick(); @(negedge CLK);
    chk("err_c3_ramaddr", bus.ramaddr,    32'h44);
    chk("err_c3_iwait",   32'(bus.iwait), 32'd0);
    tick();
    bus.iREN = 1'b0;
    @(negedge CLK);

    chk("sb_iq_empty", 32'(iq.size()), 32'd0);
    chk("sb_dq_empty", 32'(dq.size()), 32'd0);

    // Asynchronous reset in the middle of an IGRANT
    lat = 6;
    bus.iREN = 1'b1; bus.iaddr = 32'h4C;
    tick(); @(negedge CLK);
    chk("arst_pre_ramREN", 32'(bus.ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("arst_iwait",  32'(bus.iwait),  32'd1);
    chk("arst_dwait",  32'(bus.dwait),  32'd1);
    chk("arst_iload",  bus.iload,       32'd0);
    chk("arst_dload",  bus.dload,       32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    bus.iREN = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    chk("arst_idle_ramREN", 32'(bus.ramREN), 32'd0);
    chk("arst_idle_iwait",  32'(bus.iwait),  32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
